// File: rtl/chan_pkt_framer.sv
// chan_pkt_framer: buffers the channelizer sample stream in a small FIFO and
// cuts it into fixed-length packets with tlast / end-of-burst marking.
// Optional macro CHAN_PKT_FRAMER_PAD_EN: on end-of-burst, stall input, drain
// the FIFO and pad the open packet with zero beats up to full length.
module chan_pkt_framer #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_AWIDTH = 5
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [LEN_WIDTH-1:0]  payload_length,
  input  logic                  eob_req,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_eob,
  output logic [31:0]           pkt_count
);

  localparam int DEPTH = 2 ** FIFO_AWIDTH;
  localparam logic [FIFO_AWIDTH:0] DEPTH_CNT = (FIFO_AWIDTH + 1)'(DEPTH);

`ifdef CHAN_PKT_FRAMER_PAD_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [FIFO_AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AWIDTH:0]   cnt_q;
  logic                   ready_en_q;
  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q, pkt_len_q;
  logic                   eob_pend_q, eob_tag_q;
  logic                   out_valid_q, out_last_q, out_eob_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [31:0]            pkt_count_q;

  logic                   fifo_full, fifo_empty, push, pop, load, load_ok, out_hs;
  logic                   flush_stall, is_last, ld_last, ld_eob;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic [LEN_WIDTH:0]     len_p1;
  logic [LEN_WIDTH-1:0]   len_beats, len_new, cur_len;
`ifdef CHAN_PKT_FRAMER_PAD_EN
  logic                   pad_sel;
`endif

  assign fifo_full  = (cnt_q == DEPTH_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = s_axis_tvalid && s_axis_tready;
  assign out_hs     = out_valid_q && m_axis_tready;
  assign load_ok    = !out_valid_q || m_axis_tready;

  // Beats per packet from the byte-length setting; a packet is never empty.
  assign len_p1    = {1'b0, payload_length} + (LEN_WIDTH + 1)'(1);
  assign len_beats = LEN_WIDTH'(len_p1 >> 2);
  assign len_new   = (len_beats == '0) ? LEN_WIDTH'(1) : len_beats;
  // A new packet uses the live setting; an open packet keeps its latched one.
  assign cur_len   = (state_q == IDLE) ? len_new : pkt_len_q;
  assign is_last   = (beat_cnt_q == cur_len - LEN_WIDTH'(1));

  // Select what the output register loads next and how it is marked.
  always_comb begin
    ld_data     = mem_q[rd_ptr_q];
    ld_last     = is_last;
    ld_eob      = 1'b0;
    load        = load_ok && !fifo_empty;
    flush_stall = 1'b0;
`ifdef CHAN_PKT_FRAMER_PAD_EN
    flush_stall = eob_pend_q;
    pad_sel     = eob_pend_q && !eob_tag_q && fifo_empty;
    if (pad_sel) begin
      ld_data = '0;
      ld_last = (state_q == IDLE) || is_last;
      ld_eob  = ld_last;
      load    = load_ok;
    end
`else
    if (eob_pend_q && !eob_tag_q) begin
      ld_last = 1'b1;
      ld_eob  = 1'b1;
    end
`endif
    pop = load && !fifo_empty;
  end

  assign s_axis_tready = ready_en_q && !fifo_full && !flush_stall;

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  // FIFO pointers, framing FSM, output register and burst tracking.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      pkt_len_q   <= '0;
      eob_pend_q  <= 1'b0;
      eob_tag_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_eob_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AWIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AWIDTH'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (FIFO_AWIDTH + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AWIDTH + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase

      // tlast is decided when a beat enters the output register, so the
      // counter tracks loaded beats; they leave in order, which is equivalent.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_data;
        out_last_q  <= ld_last;
        out_eob_q   <= ld_eob;
        if (ld_last) begin
          state_q    <= IDLE;
          beat_cnt_q <= '0;
        end else begin
          beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
          if (state_q == IDLE) pkt_len_q <= len_new;
`ifdef CHAN_PKT_FRAMER_PAD_EN
          state_q <= pad_sel ? FLUSH : ACTIVE;
`else
          state_q <= ACTIVE;
`endif
        end
        if (ld_eob) eob_tag_q <= 1'b1;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end

      if (out_hs && out_last_q) pkt_count_q <= pkt_count_q + 32'd1;

      // eob_tag_q stops a second beat being tagged before the first leaves.
      if (out_hs && out_eob_q) begin
        eob_pend_q <= 1'b0;
        eob_tag_q  <= 1'b0;
      end else if (eob_req) begin
        eob_pend_q <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_eob    = out_eob_q;
  assign pkt_count     = pkt_count_q;

endmodule
